fetch_queue: RTL and testbench

- Instruction queue between the fetch stage (PC register plus synchronous instruction memory) and decode/dispatch.
- Fetch pushes one {pc, instruction} pair per cycle; dispatch pops through a valid/ready handshake.
- The block generates the queue_full stall that freezes PC updates.
- A flush input empties the queue on branch redirect.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch and decode/dispatch.
// Each entry is {pc, instruction}. The fetch side pushes at most one entry
// per cycle. The dispatch side pops through a valid/ready handshake.
//
// Handshake: the head entry transfers on a rising edge where deq_valid and
// deq_ready are both high and flush is low. deq_valid does not depend on
// deq_ready. While deq_valid is high and deq_ready is low, deq_pc and
// deq_instruction hold their values.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int SKID  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_instruction,
    output logic                       queue_full,
    input  logic                       flush,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_instruction,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // queue_full rises SKID entries early. The synchronous instruction memory
    // can still deliver one word after the PC freezes, and this margin leaves
    // room for that word.
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - SKID);

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;
    logic          wr_en;
    logic [63:0]   wr_data;

    // The head is read combinationally. There is no bypass, so a new entry
    // becomes visible one cycle after it is pushed.
    assign deq_valid                   = (count_q != '0);
    assign queue_full                  = (count_q >= FULL_C);
    assign {deq_pc, deq_instruction}   = mem_q[head_q];
    assign count                       = count_q;
    assign overflow                    = overflow_q;

    // Work out the push and pop for this cycle, then the next pointer, count and overflow state.
    always_comb begin
        pop        = deq_valid && deq_ready && !flush;
        // A push into a full queue is allowed when the head is freed in the same cycle.
        push       = fetch_valid && !flush && ((count_q != DEPTH_C) || pop);
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wr_en      = push;
        wr_data    = {fetch_pc, fetch_instruction};
        // A dropped push sets overflow. Only reset clears it; flush leaves it set.
        overflow_d = overflow_q |
                     (fetch_valid && !flush && (count_q == DEPTH_C) && !pop);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + PW'(1);
            if (push) tail_d = tail_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Register the pointers, count and overflow, and write the storage. The storage is cleared on reset so the head outputs never carry X.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (wr_en) begin
                mem_q[tail_q] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with DEPTH=8 and SKID=1.
// The driver pushes the expected {pc, instruction} pairs into exp_q. A
// separate monitor pops exp_q and compares on every dequeue handshake.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instruction;
    logic        queue_full;
    logic        flush;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instruction;
    logic [3:0]  count;
    logic        overflow;

    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    fetch_queue #(.DEPTH(8), .SKID(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_instruction (fetch_instruction),
        .queue_full        (queue_full),
        .flush             (flush),
        .deq_ready         (deq_ready),
        .deq_valid         (deq_valid),
        .deq_pc            (deq_pc),
        .deq_instruction   (deq_instruction),
        .count             (count),
        .overflow          (overflow)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs are set #1 after a rising edge and held through the next edge.
    task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
        fetch_valid       = fv;
        fetch_pc          = pc;
        fetch_instruction = ins;
        deq_ready         = rdy;
        flush             = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
        exp_q.push_back({pc, ins});
        cyc(1'b1, pc, ins, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    // scoreboard monitor: sample on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (reset && deq_valid && deq_ready && !flush) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL deq_unexpected: actual=0x%0h required=none", {deq_pc, deq_instruction});
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({deq_pc, deq_instruction} !== e) begin
                    n_fail++;
                    $display("FAIL deq_data: actual=0x%0h required=0x%0h", {deq_pc, deq_instruction}, e);
                end
            end
        end
        if (reset && count > 4'd8) begin
            n_tests++;
            n_fail++;
            $display("FAIL count_range: actual=%0d required=<=8", count);
        end
        assert (count <= 4'd8);
    end

    initial begin
        int i;
        int c;
        reset = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_instruction = '0;
        deq_ready = 1'b0; flush = 1'b0;

        // reset then idle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1'b0);
        check("rst_deq_valid",  64'(deq_valid),  64'd0);
        check("rst_count",      64'(count),      64'd0);
        check("rst_queue_full", 64'(queue_full), 64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);

        // single pass, one-cycle latency
        push_exp(32'h0, 32'h00500093, 1'b1);
        check("single_valid", 64'(deq_valid), 64'd1);
        check("single_pc",    64'(deq_pc), 64'h0);
        check("single_instr", 64'(deq_instruction), 64'h00500093);
        idle(1'b1);
        check("single_count_after", 64'(count), 64'd0);

        // fill to the stall point, then full
        for (int k = 0; k < 7; k++) begin
            push_exp(32'h1000 + 32'(4 * k), 32'hA0000000 + 32'(k), 1'b0);
            if (k == 5) check("fill6_queue_full", 64'(queue_full), 64'd0);
        end
        check("fill7_count",      64'(count),      64'd7);
        check("fill7_queue_full", 64'(queue_full), 64'd1);
        push_exp(32'h101C, 32'hA0000007, 1'b0);
        check("fill8_count",    64'(count),    64'd8);
        check("fill8_overflow", 64'(overflow), 64'd0);

        // full with simultaneous push and pop
        push_exp(32'h2000, 32'hB0000000, 1'b1);
        check("full_pp_count",    64'(count),    64'd8);
        check("full_pp_overflow", 64'(overflow), 64'd0);

        // overflow: push into a full queue with no pop
        cyc(1'b1, 32'hDEAD, 32'hDEADBEEF, 1'b0, 1'b0);
        check("ovf_flag",  64'(overflow), 64'd1);
        check("ovf_count", 64'(count),    64'd8);
        check("ovf_head",  {deq_pc, deq_instruction}, {32'h1004, 32'hA0000001});

        // drain: the entry pushed at full comes out eighth
        repeat (8) idle(1'b1);
        check("drain_count", 64'(count), 64'd0);
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

        // wrap-around stream with ready pattern 1,1,0; fetch stalls on queue_full
        i = 0;
        c = 0;
        while (i < 20 && c < 200) begin
            if (!queue_full) begin
                push_exp(32'(4 * i), 32'hC0DE0000 | 32'(i), (c % 3) != 2);
                i++;
            end else begin
                idle((c % 3) != 2);
            end
            c++;
        end
        check("wrap_all_issued", 64'(i), 64'd20);
        c = 0;
        while (count != 0 && c < 40) begin
            idle(1'b1);
            c++;
        end
        check("wrap_count", 64'(count), 64'd0);
        check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // flush mid-stream
        for (int k = 0; k < 5; k++) push_exp(32'h3000 + 32'(4 * k), 32'hD0000000 + 32'(k), 1'b0);
        check("flush_pre_count", 64'(count), 64'd5);
        exp_q.delete();
        cyc(1'b1, 32'h999, 32'h99999999, 1'b1, 1'b1);
        check("flush_count", 64'(count),     64'd0);
        check("flush_valid", 64'(deq_valid), 64'd0);
        check("flush_keeps_ovf", 64'(overflow), 64'd1);
        push_exp(32'h100, 32'h00100113, 1'b0);
        check("post_flush_count", 64'(count), 64'd1);
        check("post_flush_pc",    64'(deq_pc), 64'h100);
        idle(1'b1);
        idle(1'b0);
        check("post_flush_sb_empty", 64'(exp_q.size()), 64'd0);

        // reset in the same cycle as flush and a push
        for (int k = 0; k < 3; k++) push_exp(32'h4000 + 32'(4 * k), 32'hE0000000 + 32'(k), 1'b0);
        exp_q.delete();
        reset = 1'b0;
        cyc(1'b1, 32'h5000, 32'h55555555, 1'b1, 1'b1);
        reset = 1'b1;
        idle(1'b0);
        check("rst2_count",      64'(count),      64'd0);
        check("rst2_valid",      64'(deq_valid),  64'd0);
        check("rst2_queue_full", 64'(queue_full), 64'd0);
        check("rst2_overflow",   64'(overflow),   64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
